// File: rtl/hline_sched.sv
// hline_sched: command queue and job sequencer for the hline z-buffer engine.
//
// Software pushes 256-bit hline commands into a DEPTH-entry FIFO. A small FSM
// pops one command at a time into the eng_* holding registers, pulses
// eng_start, waits for the engine to leave and then re-enter its DONE state,
// and retires the job. Retiring captures the engine's final z accumulator and
// counts the job. A watchdog abandons any job that runs for TIMEOUT cycles.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   cmd_valid/ready    command push handshake (see below)
//   cmd_*              eight 32-bit hline parameters for one command
//   eng_start          one-cycle start pulse to the engine
//   eng_*              parameters of the job in flight (held until retire)
//   eng_done           engine idle/DONE level
//   eng_z_sum          engine final z accumulator, valid while eng_done is high
//   busy               job in flight or FIFO non-empty
//   q_count            FIFO occupancy, 0..DEPTH
//   jobs_done          retired-job counter, wraps at 0xFFFF
//   last_z_sum         eng_z_sum captured at the most recent retire
//   overflow, timeout  sticky status flags
//   clr_status         synchronous clear of overflow, timeout and jobs_done
//   state_dbg          current FSM state (IDLE=0 ISSUE=1 WAIT_ACK=2 WAIT_DONE=3 RETIRE=4)
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high when the FIFO is not full, and
// also when it is full but the FSM pops the head in the same cycle, so a push
// and a pop together always both take effect. cmd_valid while cmd_ready is
// low drops the command and sets overflow.
module hline_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_fb_addr,
  input  logic [31:0] cmd_zbuff_addr,
  input  logic [31:0] cmd_dx,
  input  logic [31:0] cmd_slope,
  input  logic [31:0] cmd_z1,
  input  logic [31:0] cmd_rem,
  input  logic [31:0] cmd_err,
  input  logic [31:0] cmd_rgbx,
  output logic        eng_start,
  output logic [31:0] eng_fb_addr,
  output logic [31:0] eng_zbuff_addr,
  output logic [31:0] eng_dx,
  output logic [31:0] eng_slope,
  output logic [31:0] eng_z1,
  output logic [31:0] eng_rem,
  output logic [31:0] eng_err,
  output logic [31:0] eng_rgbx,
  input  logic        eng_done,
  input  logic [31:0] eng_z_sum,
  output logic        busy,
  output logic [4:0]  q_count,
  output logic [15:0] jobs_done,
  output logic [31:0] last_z_sum,
  output logic        overflow,
  output logic        timeout,
  input  logic        clr_status,
  output logic [2:0]  state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RETIRE    = 3'd4
  } state_t;

  state_t         state;
  logic [255:0]   mem [0:DEPTH-1];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [4:0]     count;
  logic [255:0]   job_q;
  logic [31:0]    wd;
  logic [31:0]    wd_next;
  logic           wd_expire;
  logic           push;
  logic           pop;

  // The pop decision depends only on registered state, so cmd_ready never
  // depends combinationally on cmd_valid.
  assign pop       = (state == S_IDLE) && (count != 5'd0);
  assign cmd_ready = (count != DEPTH_C) || pop;
  assign push      = cmd_valid && cmd_ready;

  assign wd_next   = wd + 32'd1;
  assign wd_expire = (wd_next >= 32'(TIMEOUT));

  assign busy      = (state != S_IDLE) || (count != 5'd0);
  assign q_count   = count;
  assign state_dbg = state;

  assign {eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope,
          eng_z1, eng_rem, eng_err, eng_rgbx} = job_q;

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope,
                      cmd_z1, cmd_rem, cmd_err, cmd_rgbx};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (clr_status)
        overflow <= 1'b0;
      else if (cmd_valid && !cmd_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      eng_start  <= 1'b0;
      job_q      <= '0;
      wd         <= 32'd0;
      jobs_done  <= 16'd0;
      last_z_sum <= 32'd0;
      timeout    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            job_q     <= mem[rd_ptr];
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= 32'd0;
          state <= S_WAIT_ACK;
        end
        // The engine must be seen leaving DONE before its DONE level can be
        // trusted as completion of this job rather than the previous one.
        S_WAIT_ACK: begin
          wd <= wd_next;
          if (!eng_done) begin
            state <= S_WAIT_DONE;
          end else if (wd_expire) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          wd <= wd_next;
          if (eng_done) begin
            state <= S_RETIRE;
          end else if (wd_expire) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_RETIRE: begin
          last_z_sum <= eng_z_sum;
          jobs_done  <= jobs_done + 16'd1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so a clear overrides a same-cycle retire or timeout.
      if (clr_status) begin
        jobs_done <= 16'd0;
        timeout   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hline_sched.sv
// Bench for hline_sched: directed command sequences, a behavioural engine
// model, and a scoreboard of expected job parameters checked at each issue.
module tb_hline_sched;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RETIRE    = 3'd4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope;
  logic [31:0] cmd_z1, cmd_rem, cmd_err, cmd_rgbx;
  logic        eng_start;
  logic [31:0] eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope;
  logic [31:0] eng_z1, eng_rem, eng_err, eng_rgbx;
  logic        eng_done;
  logic [31:0] eng_z_sum;
  logic        busy;
  logic [4:0]  q_count;
  logic [15:0] jobs_done;
  logic [31:0] last_z_sum;
  logic        overflow;
  logic        timeout;
  logic        clr_status;
  logic [2:0]  state_dbg;

  hline_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fb_addr(cmd_fb_addr), .cmd_zbuff_addr(cmd_zbuff_addr),
    .cmd_dx(cmd_dx), .cmd_slope(cmd_slope), .cmd_z1(cmd_z1),
    .cmd_rem(cmd_rem), .cmd_err(cmd_err), .cmd_rgbx(cmd_rgbx),
    .eng_start(eng_start),
    .eng_fb_addr(eng_fb_addr), .eng_zbuff_addr(eng_zbuff_addr),
    .eng_dx(eng_dx), .eng_slope(eng_slope), .eng_z1(eng_z1),
    .eng_rem(eng_rem), .eng_err(eng_err), .eng_rgbx(eng_rgbx),
    .eng_done(eng_done), .eng_z_sum(eng_z_sum),
    .busy(busy), .q_count(q_count), .jobs_done(jobs_done),
    .last_z_sum(last_z_sum), .overflow(overflow), .timeout(timeout),
    .clr_status(clr_status), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [255:0] exp_q[$];
  int           starts = 0;
  int           last_start_cyc = 0;
  logic [255:0] inflight_vec = '0;
  logic [31:0]  inflight_z = '0;
  int           eng_lat = 20;
  logic         eng_hang = 1'b0;

  logic [255:0] eng_vec;
  assign eng_vec = {eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope,
                    eng_z1, eng_rem, eng_err, eng_rgbx};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] job_vec(input logic [31:0] id, input logic [31:0] dx,
                                           input logic [31:0] z1);
    return {32'hF000_0000 | id, 32'hE000_0000 | id, dx, 32'h0001_0000 + id,
            z1, id, ~id, 32'h00FF_0000 | id};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic [31:0] id, input logic [31:0] dx,
                           input logic [31:0] z1, output logic ok);
    logic [255:0] v;
    v = job_vec(id, dx, z1);
    cmd_valid = 1'b1;
    {cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope,
     cmd_z1, cmd_rem, cmd_err, cmd_rgbx} = v;
    ok = cmd_ready;
    if (ok) exp_q.push_back(v);
  endtask

  task automatic push_job(input logic [31:0] id, input logic [31:0] dx,
                          input logic [31:0] z1, output logic ok);
    @(negedge clk);
    drive_cmd(id, dx, z1, ok);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    int n;
    n = 0;
    while (state_dbg !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg !== st) check(name, 32'(state_dbg), 32'(st));
  endtask

  // ---------------- engine model ----------------
  // Leaves DONE on start, returns to DONE eng_lat cycles later with
  // z_sum = z1 + 15*dx; while eng_hang is set it never completes.
  initial begin
    int cnt;
    eng_done  = 1'b1;
    eng_z_sum = 32'd0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        eng_done = 1'b0;
        cnt = 0;
        forever begin
          @(negedge clk);
          if (eng_start) cnt = 0;
          else cnt++;
          if (!eng_hang && cnt >= eng_lat) break;
        end
        eng_z_sum = eng_z1 + eng_dx * 32'd15;
        eng_done  = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic retire_prev;
    logic [255:0] v;
    retire_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        retire_prev = 1'b0;
      end else begin
        if (retire_prev) check("retire_z_sum", last_z_sum, inflight_z);
        if (state_dbg == S_RETIRE) check_vec("eng_params_held", eng_vec, inflight_vec);
        retire_prev = (state_dbg == S_RETIRE);
        if (eng_start) begin
          starts++;
          last_start_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_start: got eng_start with params %h, expected no job", eng_vec);
          end else begin
            v = exp_q.pop_front();
            check_vec("issue_params", eng_vec, v);
            inflight_vec = v;
            inflight_z   = v[127:96] + v[191:160] * 32'd15;
          end
        end
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ok;
    logic oks [5];
    logic hit;
    int   lat;
    int   s0;
    int   n;

    reset = 1'b1;
    cmd_valid = 1'b0;
    clr_status = 1'b0;
    {cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope,
     cmd_z1, cmd_rem, cmd_err, cmd_rgbx} = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);
    check("rst_last_z_sum", last_z_sum, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check_vec("rst_eng_params", eng_vec, 256'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Single job: dx=0x10, z1=0x100 -> z_sum 0x1F0
    push_job(32'd1, 32'h10, 32'h100, ok);
    check("t1_accept", 32'(ok), 32'd1);
    idle_bus();
    wait_idle("t1_idle", 200);
    check("t1_starts", 32'(starts), 32'd1);
    check("t1_jobs_done", 32'(jobs_done), 32'd1);
    check("t1_last_z_sum", last_z_sum, 32'h1F0);
    check("t1_busy", 32'(busy), 32'd0);

    // Overflow: 5 back-to-back pushes while a job is in flight
    push_job(32'd2, 32'd2, 32'h200, ok);
    idle_bus();
    wait_state("t2_wait_done", S_WAIT_DONE, 40);
    for (int i = 0; i < 5; i++) begin
      push_job(32'(10 + i), 32'(10 + i), 32'(i * 256 + 7), ok);
      oks[i] = ok;
    end
    idle_bus();
    for (int i = 0; i < 4; i++) check("t2_accept", 32'(oks[i]), 32'd1);
    check("t2_fifth_rejected", 32'(oks[4]), 32'd0);
    check("t2_q_count_full", 32'(q_count), 32'd4);
    check("t2_cmd_ready_full", 32'(cmd_ready), 32'd0);
    check("t2_overflow", 32'(overflow), 32'd1);
    wait_idle("t2_idle", 600);
    check("t2_jobs_done", 32'(jobs_done), 32'd6);
    check("t2_starts", 32'(starts), 32'd6);

    // Clear, then full FIFO with a push in the popping cycle
    pulse_clr();
    check("t3_clr_overflow", 32'(overflow), 32'd0);
    check("t3_clr_jobs_done", 32'(jobs_done), 32'd0);
    push_job(32'd20, 32'd3, 32'h300, ok);
    idle_bus();
    wait_state("t3_wait_done", S_WAIT_DONE, 40);
    for (int i = 0; i < 4; i++) push_job(32'(21 + i), 32'(21 + i), 32'h1000, ok);
    idle_bus();
    check("t3_q_count_full", 32'(q_count), 32'd4);
    hit = 1'b0;
    ok = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      if (state_dbg == S_IDLE && q_count == 5'd4) begin
        drive_cmd(32'd25, 32'd25, 32'h2000, ok);
        hit = 1'b1;
      end
    end
    check("t3_pop_cycle_found", 32'(hit), 32'd1);
    check("t3_push_on_pop_accept", 32'(ok), 32'd1);
    idle_bus();
    check("t3_q_count_stays", 32'(q_count), 32'd4);
    check("t3_no_overflow", 32'(overflow), 32'd0);
    wait_idle("t3_idle", 800);
    check("t3_jobs_done", 32'(jobs_done), 32'd6);

    // Watchdog: hung engine, two jobs queued
    eng_hang = 1'b1;
    s0 = starts;
    push_job(32'd30, 32'd30, 32'h3000, ok);
    push_job(32'd31, 32'd31, 32'h3100, ok);
    idle_bus();
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_set", 32'(timeout), 32'd1);
    lat = cyc - last_start_cyc;
    n_tests++;
    if (lat < TIMEOUT - 1 || lat > TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL t4_timeout_latency: got %0d cycles expected %0d +/-1", lat, TIMEOUT);
    end
    check("t4_jobs_done_unchanged", 32'(jobs_done), 32'd6);
    n = 0;
    while (starts < s0 + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_next_job_issued", 32'(starts - s0), 32'd2);
    eng_hang = 1'b0;
    wait_idle("t4_idle", 300);
    check("t4_jobs_done_after", 32'(jobs_done), 32'd7);
    check("t4_timeout_sticky", 32'(timeout), 32'd1);

    // Counter wrap and clear-wins-over-retire
    pulse_clr();
    check("t5_clr_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    force dut.jobs_done = 16'hFFFF;
    #1 release dut.jobs_done;
    push_job(32'd40, 32'd40, 32'h4000, ok);
    idle_bus();
    wait_idle("t5_idle_wrap", 200);
    check("t5_jobs_done_wrap", 32'(jobs_done), 32'd0);
    push_job(32'd41, 32'd41, 32'h4100, ok);
    idle_bus();
    hit = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      if (state_dbg == S_RETIRE) begin
        clr_status = 1'b1;
        hit = 1'b1;
      end
    end
    @(negedge clk);
    clr_status = 1'b0;
    check("t5_retire_seen", 32'(hit), 32'd1);
    check("t5_clr_wins", 32'(jobs_done), 32'd0);
    wait_idle("t5_idle", 100);

    // Asynchronous reset during WAIT_DONE with two jobs queued
    eng_lat = 40;
    push_job(32'd50, 32'd50, 32'h5000, ok);
    push_job(32'd51, 32'd51, 32'h5100, ok);
    push_job(32'd52, 32'd52, 32'h5200, ok);
    idle_bus();
    n = 0;
    while (!(state_dbg == S_WAIT_DONE && q_count == 5'd2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6_setup_q_count", 32'(q_count), 32'd2);
    check("t6_setup_state", 32'(state_dbg), 32'(S_WAIT_DONE));
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_async_state", 32'(state_dbg), 32'(S_IDLE));
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_q_count", 32'(q_count), 32'd0);
    check("t6_async_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_async_eng_start", 32'(eng_start), 32'd0);
    check_vec("t6_async_eng_params", eng_vec, 256'd0);
    check("t6_async_last_z_sum", last_z_sum, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s0 = starts;
    repeat (60) @(negedge clk);
    check("t6_no_start_after_reset", 32'(starts - s0), 32'd0);
    check("t6_idle_after_reset", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
